// File: rtl/hit_edge_pkg.sv
`default_nettype none
// ============================================================================
// Module : hit_edge_pkg
// Brief  : Edge-code constants, FSM state and edge-mask types for hit_edge_collector.
// Rev    : 1.0
// ============================================================================
package hit_edge_pkg;

   localparam int EDGE_W = 5;

   localparam logic [3:0] CENTER = 4'd0;
   localparam logic [3:0] LEFT   = 4'd1;
   localparam logic [3:0] RIGHT  = 4'd2;
   localparam logic [3:0] TOP    = 4'd3;
   localparam logic [3:0] BOTTOM = 4'd4;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_COLLECT = 2'd1,
      ST_REPORT  = 2'd2
   } state_t;

   typedef logic [EDGE_W-1:0] edge_mask_t;

endpackage
`default_nettype wire

// File: rtl/edge_code_decoder.sv
`default_nettype none
// ============================================================================
// Module : edge_code_decoder
// Brief  : 4-bit hit-edge code to 5-bit one-hot; invalid codes give zero.
// Rev    : 1.0
// ============================================================================
module edge_code_decoder
   import hit_edge_pkg::*;
(
   input  logic [3:0] code,
   output edge_mask_t onehot
);

   always_comb begin
      onehot = '0;
      case (code)
         CENTER:  onehot[0] = 1'b1;
         LEFT:    onehot[1] = 1'b1;
         RIGHT:   onehot[2] = 1'b1;
         TOP:     onehot[3] = 1'b1;
         BOTTOM:  onehot[4] = 1'b1;
         default: onehot = '0;
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/hit_edge_collector.sv
`default_nettype none
// ============================================================================
// Module : hit_edge_collector
// Brief  : Per-frame wall/bomb overlap counter with registered collision report.
//          Define HIT_PIXEL_COUNT_EN to expose the reported wall pixel count.
// Rev    : 1.0
// ============================================================================
module hit_edge_collector
   import hit_edge_pkg::*;
#(
   parameter int MIN_HIT_PIXELS = 4,
   parameter int CNT_W          = 8
) (
   input  logic             clk,
   input  logic             resetN,
   input  logic             startOfFrame,
   input  logic             playerDR,
   input  logic [3:0]       playerHitEdgeCode,
   input  logic             wallDR,
   input  logic             bombDR,
   output logic             collisionPulse,
   output logic             bombHitPulse,
   output edge_mask_t       edgeMask
`ifdef HIT_PIXEL_COUNT_EN
   ,
   output logic [CNT_W-1:0] hitPixelCount
`endif
);

   generate
      if ((longint'(MIN_HIT_PIXELS) > ((longint'(1) << CNT_W) - 1)) || (MIN_HIT_PIXELS < 0)) begin : g_min_hit_check
         $error("hit_edge_collector: MIN_HIT_PIXELS does not fit in CNT_W bits");
      end
   endgenerate

   localparam logic [CNT_W-1:0] c_cnt_max = '1;
   localparam logic [CNT_W-1:0] c_min_hit = CNT_W'(MIN_HIT_PIXELS);

   state_t           r_state;
   state_t           w_state_nxt;
   logic             w_count_en;
   logic             w_report_load;
   logic             w_restart;

   logic [CNT_W-1:0] r_wall_cnt;
   logic [CNT_W-1:0] r_bomb_cnt;
   edge_mask_t       r_acc_mask;

   logic             w_wall_hit;
   logic             w_bomb_hit;
   edge_mask_t       w_code_onehot;
   logic [CNT_W-1:0] w_wall_base;
   logic [CNT_W-1:0] w_bomb_base;
   edge_mask_t       w_mask_base;
   logic [CNT_W-1:0] w_wall_nxt;
   logic [CNT_W-1:0] w_bomb_nxt;
   edge_mask_t       w_mask_nxt;
   logic             w_wall_report;
   logic             w_bomb_report;

   edge_code_decoder u_decoder (
      .code   (playerHitEdgeCode),
      .onehot (w_code_onehot)
   );

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) r_state <= ST_IDLE;
      else         r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE:    if (startOfFrame) w_state_nxt = ST_COLLECT;
         ST_COLLECT: if (startOfFrame) w_state_nxt = ST_REPORT;
         ST_REPORT:  w_state_nxt = ST_COLLECT;
         default:    w_state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      w_count_en    = 1'b0;
      w_report_load = 1'b0;
      w_restart     = 1'b0;
      case (r_state)
         ST_COLLECT: begin
            w_count_en    = 1'b1;
            w_report_load = startOfFrame;
         end
         ST_REPORT: begin
            w_count_en = 1'b1;
            w_restart  = 1'b1;
         end
         default: ;
      endcase
   end

   // The REPORT cycle's pixel opens the next frame, so accumulation restarts from zero there.
   assign w_wall_hit  = playerDR & wallDR;
   assign w_bomb_hit  = playerDR & bombDR;
   assign w_wall_base = w_restart ? '0 : r_wall_cnt;
   assign w_bomb_base = w_restart ? '0 : r_bomb_cnt;
   assign w_mask_base = w_restart ? '0 : r_acc_mask;

   assign w_wall_nxt  = (w_wall_hit && (w_wall_base != c_cnt_max)) ? w_wall_base + 1'b1 : w_wall_base;
   assign w_bomb_nxt  = (w_bomb_hit && (w_bomb_base != c_cnt_max)) ? w_bomb_base + 1'b1 : w_bomb_base;
   assign w_mask_nxt  = w_mask_base | (w_wall_hit ? w_code_onehot : '0);

   assign w_wall_report = (w_wall_nxt >= c_min_hit);
   assign w_bomb_report = (w_bomb_nxt >= c_min_hit);

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         r_wall_cnt <= '0;
         r_bomb_cnt <= '0;
         r_acc_mask <= '0;
      end else if (w_count_en) begin
         r_wall_cnt <= w_wall_nxt;
         r_bomb_cnt <= w_bomb_nxt;
         r_acc_mask <= w_mask_nxt;
      end
   end

   // Evaluate the closing frame including its last pixel so the report is visible in REPORT.
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         collisionPulse <= 1'b0;
         bombHitPulse   <= 1'b0;
         edgeMask       <= '0;
      end else begin
         collisionPulse <= w_report_load & w_wall_report;
         bombHitPulse   <= w_report_load & w_bomb_report;
         if (w_report_load) edgeMask <= w_wall_report ? w_mask_nxt : '0;
      end
   end

`ifdef HIT_PIXEL_COUNT_EN
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN)            hitPixelCount <= '0;
      else if (w_report_load) hitPixelCount <= w_wall_nxt;
   end
`endif

endmodule
`default_nettype wire

// File: tb/tb_hit_edge_collector.sv
`default_nettype none
// ============================================================================
// Module : tb_hit_edge_collector
// Brief  : Directed self-checking bench for hit_edge_collector.
// Rev    : 1.0
// ============================================================================
module tb_hit_edge_collector;

   logic       clk;
   logic       resetN;
   logic       startOfFrame;
   logic       playerDR;
   logic [3:0] playerHitEdgeCode;
   logic       wallDR;
   logic       bombDR;
   logic       collisionPulse;
   logic       bombHitPulse;
   logic [4:0] edgeMask;
`ifdef HIT_PIXEL_COUNT_EN
   logic [7:0] hitPixelCount;
`endif

   int checks   = 0;
   int failures = 0;

   hit_edge_collector #(
      .MIN_HIT_PIXELS (4),
      .CNT_W          (8)
   ) dut (
      .clk               (clk),
      .resetN            (resetN),
      .startOfFrame      (startOfFrame),
      .playerDR          (playerDR),
      .playerHitEdgeCode (playerHitEdgeCode),
      .wallDR            (wallDR),
      .bombDR            (bombDR),
      .collisionPulse    (collisionPulse),
      .bombHitPulse      (bombHitPulse),
      .edgeMask          (edgeMask)
`ifdef HIT_PIXEL_COUNT_EN
      ,
      .hitPixelCount     (hitPixelCount)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic cyc(input logic sof, input logic pdr, input logic [3:0] code,
                      input logic wdr, input logic bdr);
      startOfFrame      = sof;
      playerDR          = pdr;
      playerHitEdgeCode = code;
      wallDR            = wdr;
      bombDR            = bdr;
      @(posedge clk);
      #1;
   endtask

   task automatic wall(input logic [3:0] code);
      cyc(1'b0, 1'b1, code, 1'b1, 1'b0);
   endtask

   task automatic idle();
      cyc(1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
   endtask

   task automatic sof();
      cyc(1'b1, 1'b0, 4'd0, 1'b0, 1'b0);
   endtask

   task automatic test_reset();
      resetN = 1'b0;
      cyc(1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
      cyc(1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
      checks++; if (collisionPulse !== 1'b0) begin failures++; $display("FAIL reset_coll: got %b want 0", collisionPulse); end
      checks++; if (bombHitPulse !== 1'b0) begin failures++; $display("FAIL reset_bomb: got %b want 0", bombHitPulse); end
      checks++; if (edgeMask !== 5'b00000) begin failures++; $display("FAIL reset_mask: got %b want 00000", edgeMask); end
      resetN = 1'b1;
   endtask

   task automatic test_basic();
      sof();
      repeat (5) wall(4'd1);
      sof();
      checks++; if (collisionPulse !== 1'b1) begin failures++; $display("FAIL basic_coll: got %b want 1", collisionPulse); end
      checks++; if (edgeMask !== 5'b00010) begin failures++; $display("FAIL basic_mask: got %b want 00010", edgeMask); end
      checks++; if (bombHitPulse !== 1'b0) begin failures++; $display("FAIL basic_bomb: got %b want 0", bombHitPulse); end
      idle();
      checks++; if (collisionPulse !== 1'b0) begin failures++; $display("FAIL basic_one_cycle: got %b want 0", collisionPulse); end
      checks++; if (edgeMask !== 5'b00010) begin failures++; $display("FAIL basic_mask_hold: got %b want 00010", edgeMask); end
   endtask

   task automatic test_threshold();
      repeat (3) wall(4'd1);
      sof();
      checks++; if (collisionPulse !== 1'b0) begin failures++; $display("FAIL thr_below_coll: got %b want 0", collisionPulse); end
      checks++; if (edgeMask !== 5'b00000) begin failures++; $display("FAIL thr_below_mask: got %b want 00000", edgeMask); end
      wall(4'd3); wall(4'd3); wall(4'd4); wall(4'd4);
      sof();
      checks++; if (collisionPulse !== 1'b1) begin failures++; $display("FAIL thr_at_coll: got %b want 1", collisionPulse); end
      checks++; if (edgeMask !== 5'b11000) begin failures++; $display("FAIL thr_at_mask: got %b want 11000", edgeMask); end
   endtask

   task automatic test_frame_boundary();
      idle();
      repeat (3) wall(4'd2);
      cyc(1'b1, 1'b1, 4'd2, 1'b1, 1'b0);
      checks++; if (collisionPulse !== 1'b1) begin failures++; $display("FAIL bnd_old_coll: got %b want 1", collisionPulse); end
      checks++; if (edgeMask !== 5'b00100) begin failures++; $display("FAIL bnd_old_mask: got %b want 00100", edgeMask); end
      wall(4'd0);
      repeat (3) wall(4'd3);
      sof();
      checks++; if (collisionPulse !== 1'b1) begin failures++; $display("FAIL bnd_new_coll: got %b want 1", collisionPulse); end
      checks++; if (edgeMask !== 5'b01001) begin failures++; $display("FAIL bnd_new_mask: got %b want 01001", edgeMask); end
   endtask

   task automatic test_invalid_code();
      idle();
      repeat (6) wall(4'd7);
      sof();
      checks++; if (collisionPulse !== 1'b1) begin failures++; $display("FAIL inv_coll: got %b want 1", collisionPulse); end
      checks++; if (edgeMask !== 5'b00000) begin failures++; $display("FAIL inv_mask: got %b want 00000", edgeMask); end
   endtask

   task automatic test_back_to_back();
      sof();
      checks++; if (collisionPulse !== 1'b0) begin failures++; $display("FAIL b2b_report_sof: got %b want 0", collisionPulse); end
      repeat (4) wall(4'd1);
      sof();
      checks++; if (collisionPulse !== 1'b1) begin failures++; $display("FAIL b2b_coll: got %b want 1", collisionPulse); end
      checks++; if (edgeMask !== 5'b00010) begin failures++; $display("FAIL b2b_mask: got %b want 00010", edgeMask); end
      idle();
      repeat (6) cyc(1'b0, 1'b0, 4'd1, 1'b1, 1'b1);
      sof();
      checks++; if (collisionPulse !== 1'b0) begin failures++; $display("FAIL noplayer_coll: got %b want 0", collisionPulse); end
      checks++; if (bombHitPulse !== 1'b0) begin failures++; $display("FAIL noplayer_bomb: got %b want 0", bombHitPulse); end
   endtask

   task automatic test_bomb();
      idle();
      repeat (3) cyc(1'b0, 1'b1, 4'd1, 1'b1, 1'b1);
      sof();
      checks++; if (bombHitPulse !== 1'b0) begin failures++; $display("FAIL bomb_below: got %b want 0", bombHitPulse); end
      checks++; if (collisionPulse !== 1'b0) begin failures++; $display("FAIL bomb_below_coll: got %b want 0", collisionPulse); end
      idle();
      repeat (300) cyc(1'b0, 1'b1, 4'd0, 1'b0, 1'b1);
      sof();
      checks++; if (bombHitPulse !== 1'b1) begin failures++; $display("FAIL bomb_sat_pulse: got %b want 1", bombHitPulse); end
      checks++; if (collisionPulse !== 1'b0) begin failures++; $display("FAIL bomb_sat_coll: got %b want 0", collisionPulse); end
      checks++; if (edgeMask !== 5'b00000) begin failures++; $display("FAIL bomb_sat_mask: got %b want 00000", edgeMask); end
`ifdef HIT_PIXEL_COUNT_EN
      checks++; if (hitPixelCount !== 8'd0) begin failures++; $display("FAIL bomb_sat_count: got %0d want 0", hitPixelCount); end
`endif
      idle();
      checks++; if (bombHitPulse !== 1'b0) begin failures++; $display("FAIL bomb_one_cycle: got %b want 0", bombHitPulse); end
`ifdef HIT_PIXEL_COUNT_EN
      repeat (300) wall(4'd2);
      sof();
      checks++; if (hitPixelCount !== 8'd255) begin failures++; $display("FAIL wall_sat_count: got %0d want 255", hitPixelCount); end
      idle();
`endif
   endtask

   task automatic test_reset_mid_frame();
      repeat (4) wall(4'd4);
      sof();
      checks++; if (edgeMask !== 5'b10000) begin failures++; $display("FAIL rst_pre_mask: got %b want 10000", edgeMask); end
      idle();
      repeat (10) wall(4'd1);
      #1 resetN = 1'b0;
      #2;
      checks++; if (edgeMask !== 5'b00000) begin failures++; $display("FAIL rst_async_mask: got %b want 00000", edgeMask); end
      checks++; if (collisionPulse !== 1'b0) begin failures++; $display("FAIL rst_async_coll: got %b want 0", collisionPulse); end
      @(posedge clk);
      #1 resetN = 1'b1;
      repeat (3) wall(4'd1);
      sof();
      checks++; if (collisionPulse !== 1'b0) begin failures++; $display("FAIL rst_first_sof: got %b want 0", collisionPulse); end
      repeat (3) wall(4'd2);
      sof();
      checks++; if (collisionPulse !== 1'b0) begin failures++; $display("FAIL rst_idle_ignored: got %b want 0", collisionPulse); end
      idle();
      repeat (4) wall(4'd2);
      sof();
      checks++; if (collisionPulse !== 1'b1) begin failures++; $display("FAIL rst_recover_coll: got %b want 1", collisionPulse); end
      checks++; if (edgeMask !== 5'b00100) begin failures++; $display("FAIL rst_recover_mask: got %b want 00100", edgeMask); end
   endtask

   initial begin
      resetN            = 1'b0;
      startOfFrame      = 1'b0;
      playerDR          = 1'b0;
      playerHitEdgeCode = 4'd0;
      wallDR            = 1'b0;
      bombDR            = 1'b0;
      test_reset();
      test_basic();
      test_threshold();
      test_frame_boundary();
      test_invalid_code();
      test_back_to_back();
      test_bomb();
      test_reset_mid_frame();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/hit_edge_collector.md
HIT_EDGE_COLLECTOR -- requirements
Module: hit_edge_collector

Interface
REQ-001 Parameter MIN_HIT_PIXELS, default 4: minimum overlapping pixels per frame for a collision to be reported.
REQ-002 Parameter CNT_W, default 8: width of the per-frame pixel counter.
REQ-003 clk  in  1  system clock; all logic is rising-edge.
REQ-004 resetN  in  1  reset resetN, asynchronous, active-low; clock clk.
REQ-005 startOfFrame  in  1  single-cycle pulse marking frame start.
REQ-006 playerDR  in  1  player bitmap drawing request for the current pixel.
REQ-007 playerHitEdgeCode  in  4  player bitmap hit-edge code for the current pixel: 0 centre, 1 left, 2 right, 3 top, 4 bottom; 5-15 invalid.
REQ-008 wallDR  in  1  wall/brick drawing request for the current pixel.
REQ-009 bombDR  in  1  bomb bitmap drawing request for the current pixel.
REQ-010 collisionPulse  out  1  one-cycle pulse when the previous frame contained a reportable wall collision.
REQ-011 bombHitPulse  out  1  one-cycle pulse when the previous frame contained a reportable bomb collision.
REQ-012 edgeMask  out  5  bit[k] is set when code k was seen on a wall-overlap pixel in the reported frame; held until the next report.

Function
REQ-013 A wall hit pixel is a cycle with playerDR=1 and wallDR=1; a bomb hit pixel is a cycle with playerDR=1 and bombDR=1.
REQ-014 The FSM has three states: IDLE (after reset; ignores pixels), COLLECT, and REPORT (exactly one cycle).
REQ-015 FSM transitions: IDLE->COLLECT on startOfFrame; COLLECT->REPORT on startOfFrame; REPORT->COLLECT unconditionally.
REQ-016 In COLLECT, each wall hit pixel increments wallCnt and sets accMask[code]; each bomb hit pixel increments bombCnt; both counters saturate at 2^CNT_W-1.
REQ-017 A wall hit pixel with an invalid code (5-15) increments wallCnt and leaves accMask unchanged.
REQ-018 On the startOfFrame cycle that leaves COLLECT, the final frame pixel is sampled first; in REPORT the snapshot is evaluated and the counters and accMask are cleared.
REQ-019 In REPORT, collisionPulse is asserted when wallCnt >= MIN_HIT_PIXELS, and edgeMask is loaded from accMask (loaded with 0 when the threshold is not met).
REQ-020 In REPORT, bombHitPulse is asserted when bombCnt >= MIN_HIT_PIXELS.
REQ-021 Pixels arriving during the REPORT cycle are counted toward the new frame.
REQ-022 A startOfFrame asserted during REPORT is ignored, and the FSM goes to COLLECT.
REQ-023 Latency: the pulses are registered and high on the cycle after the frame-closing startOfFrame.
REQ-024 MIN_HIT_PIXELS=0 reports every frame; MIN_HIT_PIXELS > 2^CNT_W-1 is a compile-time error.

Reset
REQ-025 Asynchronous assertion of resetN forces IDLE, clears the counters and accMask, and drives collisionPulse=0, bombHitPulse=0 and edgeMask=0.
REQ-026 A reset asserted during COLLECT discards the partial frame, and no report is issued for it.

Configuration
REQ-027 With HIT_PIXEL_COUNT_EN defined, the output port hitPixelCount[CNT_W-1:0] exists and is loaded with wallCnt in REPORT, held otherwise, and reset to 0.
REQ-028 Without HIT_PIXEL_COUNT_EN, the hitPixelCount port and its register are absent, and all other behaviour is identical.

Structure
REQ-029 Package hit_edge_pkg holds the edge-code constants (CENTER=0, LEFT=1, RIGHT=2, TOP=3, BOTTOM=4), the state enum typedef, and the edge-mask typedef.
REQ-030 Sub-module edge_code_decoder performs a combinational 4-bit code to 5-bit one-hot conversion and outputs zero for codes 5-15.

Verification
REQ-031 Reset, then startOfFrame, then 5 wall pixels with code 1, then startOfFrame -> next cycle collisionPulse=1 and edgeMask=5'b00010.
REQ-032 3 wall pixels with MIN_HIT_PIXELS=4 -> no collisionPulse and edgeMask=0; a following frame with 4 pixels of codes 3 and 4 -> collisionPulse=1 and edgeMask=5'b11000.
REQ-033 Hit pixel coincident with the closing startOfFrame, plus a hit pixel in the REPORT cycle -> first pixel counted in the old frame, second counted in the new frame.
REQ-034 300 consecutive bomb pixels -> bombCnt saturates at 255, bombHitPulse=1, and (with HIT_PIXEL_COUNT_EN) hitPixelCount=0.
REQ-035 resetN pulled low mid-COLLECT after 10 wall pixels -> all outputs 0 and no pulse at the next startOfFrame (FSM is in IDLE).
REQ-036 6 wall pixels all with code 7 -> collisionPulse=1 and edgeMask=0.
